atm_timeout_scheduler: RTL
==========================

ATM_TIMEOUT_SCHEDULER -- requirements
Module: atm_timeout_scheduler

Interface
REQ-001 Parameter WIDTH, default 8; sets the timer counter width and the limit width.
REQ-002 Port clk  input  1; single system clock, all logic on posedge.
REQ-003 Port rst  input  1; synchronous, active-high reset.
REQ-004 Port tick  input  1; one-cycle slow-time enable pulse; the timer advances only on cycles where tick=1.
REQ-005 Port start  input  2; start[i] is a one-cycle request pulse from requester i (0 = PIN-entry timeout, 1 = card-return timeout).
REQ-006 Port limit0, limit1  input  WIDTH each; tick count for requester 0/1, sampled on the cycle its start pulse is accepted.
REQ-007 Port cancel  input  2; cancel[i] is a one-cycle pulse that withdraws requester i.
REQ-008 Port busy  output  1; high while the state is RUN.
REQ-009 Port owner  output  1; index of the requester currently holding the timer.
REQ-010 Port count_q  output  WIDTH; current timer value.
REQ-011 Port expire  output  2; expire[i] is a one-cycle pulse when requester i's timeout completes.
REQ-012 Port pending  output  2; pending[i] is high while requester i waits for the timer.

Function
REQ-013 The FSM has three states: IDLE, RUN and DONE.
REQ-014 In IDLE, a start pulse moves the FSM to RUN on the next cycle, with owner=i, count_q=0 and limit=limit_i latched.
REQ-015 If start=2'b11 arrives in IDLE, requester 0 is granted and requester 1 becomes pending with limit1 latched.
REQ-016 In RUN with tick=1, count_q increments by 1, wrapping modulo 2^WIDTH.
REQ-017 When the incremented value equals the latched limit, the FSM enters DONE on the next cycle.
REQ-018 A latched limit of 0 therefore expires after exactly 2^WIDTH ticks (256 at default width).
REQ-019 DONE lasts exactly one cycle, with expire[owner]=1 during that cycle; expire is 0 in every other cycle.
REQ-020 DONE -> RUN (owner switched to the pending requester, count_q=0, that requester's pending cleared) if the other requester is pending; otherwise DONE -> IDLE.
REQ-021 A start from the owner while in RUN is a retrigger: count_q=0 and the limit is reloaded on the next cycle; no expire is produced.
REQ-022 A start from the non-owner while in RUN or DONE sets its pending bit and latches its limit; a repeated start while already pending overwrites that latched limit.
REQ-023 A cancel from the owner in RUN leaves RUN on the next cycle with no expire pulse, taking the same next-state path as DONE (serve the pending requester, else IDLE).
REQ-024 A cancel from a pending requester clears its pending bit; a cancel in IDLE has no effect.
REQ-025 Same-cycle priority, highest first:
- rst;
- owner cancel;
- owner start (retrigger);
- tick/expiry.
REQ-026 A non-owner cancel and start in the same cycle leave the pending bit set.
REQ-027 When limit is matched, count_q holds that value during DONE; in IDLE, count_q holds its last value.
REQ-028 A tick in IDLE or DONE has no effect.

Reset
REQ-029 While rst=1 at a clock edge, the following are cleared regardless of all other inputs:
- state=IDLE;
- count_q=0, owner=0, expire=0, pending=0;
- both latched limits=0.
REQ-030 Reset asserted mid-RUN aborts the timeout with no expire pulse; the first start accepted after reset behaves per REQ-014.

Structure
REQ-031 The FSM state encodings (IDLE=0, RUN=1, DONE=2) and the default WIDTH constant live in the shared package atm_timer_pkg.
REQ-032 The counter is a sub-module timer_counter8 with ports clk, rst, clr, en and q[WIDTH-1:0]. It clears when clr=1 and increments when en=1, with clr taking priority; the scheduler drives clr and en.

Verification
REQ-033 start=01, limit0=3, tick every 4th cycle -> busy after 1 cycle; count_q steps 1,2,3; expire=01 for exactly one cycle; then IDLE.
REQ-034 start=11, limit0=2, limit1=5, continuous ticks -> expire[0] pulses after 2 ticks; DONE -> RUN with owner=1, pending=00; expire[1] pulses after 5 further ticks.
REQ-035 Owner 0 running at count_q=2 of limit 4; pulse start[0] together with tick -> count_q=0; expire[0] pulses only 4 ticks later.
REQ-036 limit0=0, continuous ticks -> count_q wraps 255->0, and expire[0] pulses exactly on the 256th tick.
REQ-037 Owner 0 in RUN, requester 1 pending; pulse cancel[0] and tick in the same cycle -> no expire[0]; the next cycle has owner=1, count_q=0.
REQ-038 Assert rst mid-RUN at count_q=7 -> next cycle shows IDLE, count_q=0, pending=00, expire=00; no expire pulse at any point afterwards without a new start.

Source files
------------

// File: rtl/atm_timer_pkg.sv
// Shared constants and FSM state encoding for the ATM timeout scheduler.
package atm_timer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/timer_counter8.sv
// Free-running tick counter with synchronous clear; clear wins over enable.
module timer_counter8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/atm_timeout_scheduler.sv
// Shares one tick timer between two requesters (PIN entry, card return);
// the second requester queues as pending until the current timeout ends.
module atm_timeout_scheduler
  import atm_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [1:0]       start,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] limit1,
  input  logic [1:0]       cancel,
  output logic             busy,
  output logic             owner,
  output logic [WIDTH-1:0] count_q,
  output logic [1:0]       expire,
  output logic [1:0]       pending
);

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic [1:0]             pending_q, pending_d;
  logic [1:0][WIDTH-1:0]  limit_q, limit_d;
  logic [1:0][WIDTH-1:0]  limit_in;
  logic [WIDTH-1:0]       limit_act;
  logic [WIDTH-1:0]       cnt_inc;
  logic                   other;
  logic                   serve_next;
  logic                   cnt_clr;
  logic                   cnt_en;

  assign limit_in  = {limit1, limit0};
  assign other     = ~owner_q;
  assign limit_act = limit_q[owner_q];
  assign cnt_inc   = count_q + WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    pending_d  = pending_q;
    limit_d    = limit_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    serve_next = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start[0]) begin
          state_d    = ST_RUN;
          owner_d    = 1'b0;
          cnt_clr    = 1'b1;
          limit_d[0] = limit0;
          if (start[1]) begin
            pending_d[1] = 1'b1;
            limit_d[1]   = limit1;
          end
        end else if (start[1]) begin
          state_d    = ST_RUN;
          owner_d    = 1'b1;
          cnt_clr    = 1'b1;
          limit_d[1] = limit1;
        end
      end

      ST_RUN, ST_DONE: begin
        // A start from the waiting side beats its own cancel in the same cycle.
        if (start[other]) begin
          pending_d[other] = 1'b1;
          limit_d[other]   = limit_in[other];
        end else if (cancel[other]) begin
          pending_d[other] = 1'b0;
        end

        if (state_q == ST_RUN) begin
          if (cancel[owner_q]) begin
            serve_next = 1'b1;
          end else if (start[owner_q]) begin
            cnt_clr          = 1'b1;
            limit_d[owner_q] = limit_in[owner_q];
          end else if (tick) begin
            cnt_en = 1'b1;
            if (cnt_inc == limit_act) begin
              state_d = ST_DONE;
            end
          end
        end else begin
          serve_next = 1'b1;
        end

        // Leaving RUN/DONE hands the timer to the waiting requester, if any.
        if (serve_next) begin
          if (pending_d[other]) begin
            state_d          = ST_RUN;
            owner_d          = other;
            pending_d[other] = 1'b0;
            cnt_clr          = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      pending_q <= 2'b00;
      limit_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      pending_q <= pending_d;
      limit_q   <= limit_d;
    end
  end

  timer_counter8 #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (count_q)
  );

  assign busy    = (state_q == ST_RUN);
  assign owner   = owner_q;
  assign pending = pending_q;
  assign expire  = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
